// File: rtl/maze_run_sequencer_if.sv
// Signal bundle between the run sequencer and the explorer, wall-sensor
// front end and motion executor. master = sequencer side, slave = environment.
interface maze_run_sequencer_if;
  logic       start;
  logic       sense_req;
  logic       sense_valid;
  logic [2:0] sense_walls;
  logic       left;
  logic       mid;
  logic       right;
  logic [2:0] exp_move;
  logic [2:0] motor_cmd;
  logic       motor_req;
  logic       motor_ack;
  logic [3:0] row;
  logic [3:0] col;
  logic [1:0] heading;
  logic [7:0] move_count;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    input  start, sense_valid, sense_walls, exp_move, motor_ack,
    output sense_req, left, mid, right, motor_cmd, motor_req,
           row, col, heading, move_count, busy, done, error, err_code
  );

  modport slave (
    output start, sense_valid, sense_walls, exp_move, motor_ack,
    input  sense_req, left, mid, right, motor_cmd, motor_req,
           row, col, heading, move_count, busy, done, error, err_code
  );
endinterface

// File: rtl/maze_run_sequencer.sv
// Run-level maze controller: sense walls, hand them to the explorer, issue its
// move to the motion executor, then track position/heading until the exit cell.
module maze_run_sequencer #(
  parameter int GRID      = 9,
  parameter int START_ROW = 4,
  parameter int START_COL = 0,
  parameter int EXIT_ROW  = 4,
  parameter int EXIT_COL  = 8,
  parameter int MAX_MOVES = 200,
  parameter int TIMEOUT   = 1023
) (
  input logic                  clk,
  input logic                  rst,
  maze_run_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       START_ROW_C = 4'(START_ROW);
  localparam logic [3:0]       START_COL_C = 4'(START_COL);
  localparam logic [3:0]       EXIT_ROW_C  = 4'(EXIT_ROW);
  localparam logic [3:0]       EXIT_COL_C  = 4'(EXIT_COL);
  localparam logic [3:0]       LAST_IDX    = 4'(GRID - 1);
  localparam logic [7:0]       MAX_MOVES_C = 8'(MAX_MOVES);

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_S = 2'd1;
  localparam logic [1:0] HEAD_E = 2'd2;
  localparam logic [1:0] HEAD_W = 2'd3;

  localparam logic [2:0] MV_FWD   = 3'd1;
  localparam logic [2:0] MV_LEFT  = 3'd2;
  localparam logic [2:0] MV_RIGHT = 3'd3;
  localparam logic [2:0] MV_UTURN = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MOVE    = 2'd1;
  localparam logic [1:0] ERR_OFFGRID = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    IDLE, SENSE, WAIT_SENSE, PRESENT, CAPTURE,
    ISSUE, WAIT_ACK, UPDATE, FINISH, FAULT
  } state_t;

  state_t           state_q, state_d;
  logic             upd_phase_q, upd_phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       walls_q, walls_d;
  logic [2:0]       motor_cmd_q, motor_cmd_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       heading_q, heading_d;
  logic [7:0]       move_count_q, move_count_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [1:0]       new_heading;
  logic [3:0]       step_row;
  logic [3:0]       step_col;
  logic             off_grid;

  function automatic logic [1:0] turn(input logic [1:0] h, input logic [2:0] mv);
    logic [1:0] r;
    r = h;
    case (mv)
      MV_LEFT: begin
        case (h)
          HEAD_N:  r = HEAD_W;
          HEAD_W:  r = HEAD_S;
          HEAD_S:  r = HEAD_E;
          default: r = HEAD_N;
        endcase
      end
      MV_RIGHT: begin
        case (h)
          HEAD_N:  r = HEAD_E;
          HEAD_E:  r = HEAD_S;
          HEAD_S:  r = HEAD_W;
          default: r = HEAD_N;
        endcase
      end
      MV_UTURN: r = {h[1], ~h[0]};  // N<->S and E<->W differ only in bit 0
      default:  r = h;
    endcase
    return r;
  endfunction

  // Candidate move; edges are checked before any subtraction so row/col never wrap.
  always_comb begin
    new_heading = turn(heading_q, motor_cmd_q);
    step_row    = row_q;
    step_col    = col_q;
    off_grid    = 1'b0;
    case (new_heading)
      HEAD_N: begin
        if (row_q == 4'd0) off_grid = 1'b1;
        else               step_row = row_q - 4'd1;
      end
      HEAD_S: begin
        if (row_q >= LAST_IDX) off_grid = 1'b1;
        else                   step_row = row_q + 4'd1;
      end
      HEAD_E: begin
        if (col_q >= LAST_IDX) off_grid = 1'b1;
        else                   step_col = col_q + 4'd1;
      end
      default: begin
        if (col_q == 4'd0) off_grid = 1'b1;
        else               step_col = col_q - 4'd1;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    upd_phase_d  = upd_phase_q;
    cnt_d        = cnt_q;
    walls_d      = walls_q;
    motor_cmd_d  = motor_cmd_q;
    row_d        = row_q;
    col_d        = col_q;
    heading_d    = heading_q;
    move_count_d = move_count_q;
    err_code_d   = err_code_q;

    case (state_q)
      IDLE, FINISH, FAULT: begin
        if (bus.start) begin
          state_d      = SENSE;
          row_d        = START_ROW_C;
          col_d        = START_COL_C;
          heading_d    = HEAD_N;
          move_count_d = 8'd0;
          err_code_d   = ERR_NONE;
        end
      end
      SENSE: begin
        cnt_d   = '0;
        state_d = WAIT_SENSE;
      end
      WAIT_SENSE: begin
        if (bus.sense_valid) begin
          walls_d = bus.sense_walls;
          state_d = PRESENT;
        end else if (cnt_q == CNT_LAST) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESENT: state_d = CAPTURE;
      CAPTURE: begin
        if (bus.exp_move inside {[MV_FWD:MV_UTURN]}) begin
          motor_cmd_d = bus.exp_move;
          state_d     = ISSUE;
        end else begin
          err_code_d = ERR_MOVE;
          state_d    = FAULT;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.motor_ack) begin
          upd_phase_d = 1'b0;
          state_d     = UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        // Phase 0 commits the step; phase 1 judges exit/budget on the committed values.
        if (!upd_phase_q) begin
          if (off_grid) begin
            err_code_d = ERR_OFFGRID;
            state_d    = FAULT;
          end else begin
            row_d        = step_row;
            col_d        = step_col;
            heading_d    = new_heading;
            move_count_d = move_count_q + 8'd1;
            upd_phase_d  = 1'b1;
          end
        end else begin
          upd_phase_d = 1'b0;
          if (row_q == EXIT_ROW_C && col_q == EXIT_COL_C) begin
            motor_cmd_d = 3'd0;
            state_d     = FINISH;
          end else if (move_count_q == MAX_MOVES_C) begin
            err_code_d = ERR_TIMEOUT;
            state_d    = FAULT;
          end else begin
            state_d = SENSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      upd_phase_q  <= 1'b0;
      cnt_q        <= '0;
      walls_q      <= 3'd0;
      motor_cmd_q  <= 3'd0;
      row_q        <= START_ROW_C;
      col_q        <= START_COL_C;
      heading_q    <= HEAD_N;
      move_count_q <= 8'd0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      upd_phase_q  <= upd_phase_d;
      cnt_q        <= cnt_d;
      walls_q      <= walls_d;
      motor_cmd_q  <= motor_cmd_d;
      row_q        <= row_d;
      col_q        <= col_d;
      heading_q    <= heading_d;
      move_count_q <= move_count_d;
      err_code_q   <= err_code_d;
    end
  end

  // Handshake strobes decode straight from the state register, so rst drops them at once.
  assign bus.sense_req  = (state_q == SENSE);
  assign bus.motor_req  = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign bus.busy       = !(state_q inside {IDLE, FINISH, FAULT});
  assign bus.done       = (state_q == FINISH);
  assign bus.error      = (state_q == FAULT);
  assign bus.left       = walls_q[2];
  assign bus.mid        = walls_q[1];
  assign bus.right      = walls_q[0];
  assign bus.motor_cmd  = motor_cmd_q;
  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.heading    = heading_q;
  assign bus.move_count = move_count_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_maze_run_sequencer.sv
// Directed bench for maze_run_sequencer: a move-level position/status model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_maze_run_sequencer;

  localparam int GRID      = 9;
  localparam int START_ROW = 4;
  localparam int START_COL = 0;
  localparam int EXIT_ROW  = 4;
  localparam int EXIT_COL  = 8;
  localparam int MAX_MOVES = 200;
  localparam int TO        = 1023;

  logic clk;
  logic rst;
  maze_run_sequencer_if bus_if ();

  maze_run_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Move-level model: heading N=0 S=1 E=2 W=3
  int left_of[4]  = '{3, 2, 0, 1};
  int right_of[4] = '{2, 3, 1, 0};
  int rev_of[4]   = '{1, 0, 3, 2};
  int d_row[4]    = '{-1, 1, 0, 0};
  int d_col[4]    = '{0, 0, 1, -1};

  int m_row   = START_ROW;
  int m_col   = START_COL;
  int m_head  = 0;
  int m_count = 0;
  int m_busy  = 0;
  int m_done  = 0;
  int m_error = 0;
  int m_code  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_set_home(input int busy);
    m_row = START_ROW; m_col = START_COL; m_head = 0; m_count = 0;
    m_busy = busy; m_done = 0; m_error = 0; m_code = 0;
  endfunction

  function automatic void m_fault(input int code);
    m_error = 1; m_code = code; m_busy = 0;
  endfunction

  // Returns 1 when the move would leave the grid (model left untouched then).
  function automatic bit m_move(input int mv);
    int h, nr, nc;
    case (mv)
      1:       h = m_head;
      2:       h = left_of[m_head];
      3:       h = right_of[m_head];
      default: h = rev_of[m_head];
    endcase
    nr = m_row + d_row[h];
    nc = m_col + d_col[h];
    if (nr < 0 || nr >= GRID || nc < 0 || nc >= GRID) return 1'b1;
    m_row = nr; m_col = nc; m_head = h; m_count++;
    return 1'b0;
  endfunction

  // Compare process: status outputs against the model on every cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("row",        bus_if.row,        m_row);
      chk("col",        bus_if.col,        m_col);
      chk("heading",    bus_if.heading,    m_head);
      chk("move_count", bus_if.move_count, m_count);
      chk("busy",       bus_if.busy,       m_busy);
      chk("done",       bus_if.done,       m_done);
      chk("error",      bus_if.error,      m_error);
      chk("err_code",   bus_if.err_code,   m_code);
    end
  end

  task automatic start_run();
    @(negedge clk);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    m_set_home(1);
    @(negedge clk);
    chk("start_to_sense_req", bus_if.sense_req, 1);
  endtask

  // Enters in the SENSE cycle; leaves at the negedge of the ISSUE (or FAULT) cycle.
  task automatic to_issue(input logic [2:0] walls, input int mv, input bit poke, output bit ok);
    tick();
    @(negedge clk);
    chk("sense_req_one_shot", bus_if.sense_req, 0);
    bus_if.sense_valid = 1'b1;
    bus_if.sense_walls = walls;
    bus_if.exp_move    = 3'(mv);
    if (poke) begin
      bus_if.start     = 1'b1;
      bus_if.motor_ack = 1'b1;
    end
    tick();
    bus_if.sense_valid = 1'b0;
    bus_if.sense_walls = ~walls;
    bus_if.start       = 1'b0;
    bus_if.motor_ack   = 1'b0;
    @(negedge clk);
    chk("walls_presented", {bus_if.left, bus_if.mid, bus_if.right}, walls);
    tick();
    tick();
    bus_if.exp_move = 3'd0;
    ok = (mv >= 1 && mv <= 4);
    if (!ok) m_fault(1);
    @(negedge clk);
    chk("motor_req_issue", bus_if.motor_req, ok);
    if (ok) chk("motor_cmd", bus_if.motor_cmd, mv);
  endtask

  // ack_dly >= 1: ack that many cycles after motor_req rises; ack_dly < 0: never ack.
  task automatic step(input logic [2:0] walls, input int mv, input int ack_dly, input bit poke);
    bit ok;
    to_issue(walls, mv, poke, ok);
    if (!ok) return;
    if (ack_dly < 0) begin
      repeat (TO) begin
        tick();
        @(negedge clk);
        chk("motor_req_hold", bus_if.motor_req, 1);
      end
      tick();
      m_fault(3);
      @(negedge clk);
      chk("motor_req_after_timeout", bus_if.motor_req, 0);
      return;
    end
    repeat (ack_dly) begin
      tick();
      @(negedge clk);
      chk("motor_req_hold", bus_if.motor_req, 1);
      chk("motor_cmd_hold", bus_if.motor_cmd, mv);
    end
    bus_if.motor_ack = 1'b1;
    tick();
    bus_if.motor_ack = 1'b0;
    @(negedge clk);
    chk("motor_req_drop", bus_if.motor_req, 0);
    tick();
    if (m_move(mv)) begin
      m_fault(2);
      @(negedge clk);
      chk("motor_req_offgrid", bus_if.motor_req, 0);
      return;
    end
    tick();
    if (m_row == EXIT_ROW && m_col == EXIT_COL) begin
      m_busy = 0;
      m_done = 1;
      @(negedge clk);
      chk("finish_no_sense_req", bus_if.sense_req, 0);
      chk("finish_motor_cmd", bus_if.motor_cmd, 0);
    end else if (m_count == MAX_MOVES) begin
      m_fault(3);
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk("ack_to_sense_req", bus_if.sense_req, 1);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    rst                = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.sense_valid = 1'b0;
    bus_if.sense_walls = 3'd0;
    bus_if.exp_move    = 3'd0;
    bus_if.motor_ack   = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_sense_req", bus_if.sense_req, 0);
      chk("rst_motor_req", bus_if.motor_req, 0);
      chk("rst_motor_cmd", bus_if.motor_cmd, 0);
      chk("rst_walls", {bus_if.left, bus_if.mid, bus_if.right}, 0);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // First move: FWD with walls 101, ack 3 cycles after req
    start_run();
    step(3'b101, 1, 3, 1'b0);
    chk("t1_row", bus_if.row, 3);
    chk("t1_col", bus_if.col, 0);
    chk("t1_heading", bus_if.heading, 0);
    chk("t1_count", bus_if.move_count, 1);
    chk("t1_cmd", bus_if.motor_cmd, 1);
    step(3'b000, 0, 1, 1'b0);
    chk("stop_code", bus_if.err_code, 1);

    // LEFT from the start cell steps off the west edge
    start_run();
    step(3'b000, 2, 2, 1'b0);
    chk("offgrid_code", bus_if.err_code, 2);
    chk("offgrid_error", bus_if.error, 1);
    chk("offgrid_row", bus_if.row, 4);
    chk("offgrid_col", bus_if.col, 0);
    chk("offgrid_motor_req", bus_if.motor_req, 0);

    // Scripted run to the exit; start and ack poked while busy on move 5
    start_run();
    step(3'b110, 3, 1, 1'b0);
    for (int k = 0; k < 7; k++) step(3'b101, 1, 2, k == 3);
    chk("exit_done", bus_if.done, 1);
    chk("exit_busy", bus_if.busy, 0);
    chk("exit_count", bus_if.move_count, 8);
    chk("exit_col", bus_if.col, 8);
    bus_if.sense_valid = 1'b1;
    bus_if.motor_ack   = 1'b1;
    tick();
    bus_if.sense_valid = 1'b0;
    bus_if.motor_ack   = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_exit_sense_req", bus_if.sense_req, 0);
      tick();
    end
    start_run();
    chk("restart_row", bus_if.row, 4);
    chk("restart_col", bus_if.col, 0);
    chk("restart_done", bus_if.done, 0);

    // Sense timeout
    repeat (TO) tick();
    tick();
    m_fault(3);
    @(negedge clk);
    chk("sense_to_error", bus_if.error, 1);
    chk("sense_to_code", bus_if.err_code, 3);

    // Ack timeout
    start_run();
    step(3'b010, 1, -1, 1'b0);
    chk("ack_to_code", bus_if.err_code, 3);

    // Out-of-range move code
    start_run();
    step(3'b000, 6, 1, 1'b0);
    chk("code6_err", bus_if.err_code, 1);

    // Asynchronous reset while motor_req is high
    start_run();
    to_issue(3'b011, 4, 1'b0, ok);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_motor_req", bus_if.motor_req, 0);
    chk("async_rst_busy", bus_if.busy, 0);
    chk("async_rst_cmd", bus_if.motor_cmd, 0);
    chk("async_rst_walls", {bus_if.left, bus_if.mid, bus_if.right}, 0);
    m_set_home(0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Move budget: alternating U-turns never reach the exit
    start_run();
    for (int k = 0; k < MAX_MOVES; k++) step(3'b111, 4, 1, 1'b0);
    chk("budget_count", bus_if.move_count, 200);
    chk("budget_code", bus_if.err_code, 3);
    chk("budget_row", bus_if.row, 4);
    chk("budget_heading", bus_if.heading, 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_run_sequencer.md
Name: maze_run_sequencer

Overview:
- Run-level controller between the maze explorer decision core, the wall-sensor front end and the motion executor.
- Per step: requests a wall sample, presents the walls to the explorer, captures its move code, then issues that move to the motion executor with a req/ack handshake.
- Tracks grid position and heading (N=0, S=1, E=2, W=3) and stops the run at the exit cell.
- Flags illegal moves, off-grid positions, timeouts and move-budget overrun.

Parameters:
- GRID, 9: maze side length, in cells.
- START_ROW, 4: start row.
- START_COL, 0: start column.
- EXIT_ROW, 4: exit row.
- EXIT_COL, 8: exit column.
- MAX_MOVES, 200: move budget; reaching it raises a fault.
- TIMEOUT, 1023: maximum wait cycles for sense_valid or motor_ack.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request.
- sense_req  out  1  one-cycle wall-sample request.
- sense_valid  in  1  wall sample valid (pulse).
- sense_walls  in  3  {left, mid, right}; 1 = wall.
- left, mid, right  out  1 each  registered walls driven to the explorer.
- exp_move  in  3  explorer move: 0 STOP, 1 FWD, 2 LEFT, 3 RIGHT, 4 U_TURN.
- motor_cmd  out  3  move issued to the executor.
- motor_req  out  1  command request (level).
- motor_ack  in  1  move complete (pulse).
- row, col  out  4 each  current cell.
- heading  out  2  current heading.
- move_count  out  8  completed moves.
- busy, done, error  out  1 each  status.
- err_code  out  2  0 none, 1 illegal/STOP move, 2 off-grid, 3 timeout/budget.

Behaviour:
- Reset values (asynchronous):
  - State IDLE.
  - All outputs 0, except row=START_ROW, col=START_COL, heading=N.
- States: IDLE, SENSE, WAIT_SENSE, PRESENT, CAPTURE, ISSUE, WAIT_ACK, UPDATE, FINISH, FAULT.
- IDLE: start moves to SENSE. On entry to SENSE, reload position/heading to start values and clear move_count, done, error and err_code.
- SENSE: sense_req=1 for exactly one cycle, clear the wait counter, go to WAIT_SENSE.
- WAIT_SENSE:
  - On sense_valid, latch sense_walls into left/mid/right, go to PRESENT.
  - Counter reaching TIMEOUT goes to FAULT with code 3.
- PRESENT: walls held stable for one cycle so the explorer decides.
- CAPTURE:
  - Sample exp_move.
  - Values 1–4: latch into motor_cmd, go to ISSUE.
  - Values 0 or 5–7: FAULT with code 1.
- ISSUE: assert motor_req, clear counter, go to WAIT_ACK.
- WAIT_ACK:
  - motor_req and motor_cmd stay stable until motor_ack is sampled high.
  - Clock edge seeing ack: drop motor_req, go to UPDATE.
  - TIMEOUT: FAULT with code 3, motor_req dropped.
- UPDATE:
  - New heading: FWD unchanged; LEFT N→W→S→E→N; RIGHT N→E→S→W→N; U_TURN reversed.
  - Step one cell along the new heading: N row−1, S row+1, E col+1, W col−1.
  - Step leaving 0..GRID−1 (underflow detected before wrap): FAULT code 2, position unchanged.
  - Otherwise commit position and heading, move_count+1.
- Next-state priority after UPDATE:
  - (row, col) == exit → FINISH.
  - Else move_count == MAX_MOVES → FAULT code 3.
  - Else → SENSE.
  - Exit reached on the budget move → FINISH.
- busy=1 in every state except IDLE, FINISH and FAULT.
- FINISH: done=1, motor_cmd=0. Held until start, which begins a new run (SENSE).
- FAULT: error=1, err_code held, motor_req=0. start restarts the run.
- start while busy is ignored.
- Stray sense_valid or motor_ack outside the waiting states is ignored.
- rst asserted mid-move: motor_req drops immediately (asynchronous); all state returns to reset values.
- Latency: start to sense_req is 1 cycle. motor_ack to the updated row/col is 2 cycles. motor_ack to the next sense_req is 3 cycles.

Test Plan:
- Reset, start; sense_walls=101 (left, right), exp_move=1, ack 3 cycles after req → motor_cmd=1, row=3 col=0 heading=N, move_count=1, sense_req fires again.
- From the start cell: LEFT at heading N → step toward col −1 → FAULT, err_code=2, row=4 col=0 unchanged, motor_req=0.
- Scripted 8 RIGHT/FWD moves ending at (4,8) → done=1, busy=0, move_count=8, no further sense_req. start again → row=4 col=0, done=0.
- Withhold sense_valid for TIMEOUT cycles → error=1, err_code=3. Separately, withhold motor_ack → same, with motor_req low.
- exp_move=0 at CAPTURE → err_code=1. exp_move=6 → err_code=1.
- Assert rst while motor_req=1 → motor_req=0 in the same cycle; all outputs at reset values. start pulsed while busy → no effect.
